// File: rtl/clock_gate_pkg.sv
// clock_gate_pkg: state encodings and counter widths shared by the clock-gating controller
package clock_gate_pkg;

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_WAKE = 2'b01;
    localparam logic [1:0] ST_ON   = 2'b10;
    localparam logic [1:0] ST_IDLE = 2'b11;

    typedef enum logic [1:0] {
        OFF  = ST_OFF,
        WAKE = ST_WAKE,
        ON   = ST_ON,
        IDLE = ST_IDLE
    } cg_state_e;

    // wake_cnt only has to reach WAKE_CYC-1, and WAKE_CYC never exceeds 15
    localparam int WAKE_CNT_W = 4;

endpackage

// File: rtl/cg_channel_fsm.sv
// cg_channel_fsm: wake/idle state machine owning one gated clock domain's enable and ack
module cg_channel_fsm
    import clock_gate_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] idle_thresh,
    input  logic             force_on,
    input  logic             req,
    input  logic             busy,
    output logic             ack,
    output logic             ch_en
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYC - 1);

    cg_state_e             state, state_nxt;
    logic [WAKE_CNT_W-1:0] wake_cnt, wake_cnt_nxt;
    logic [CNT_W-1:0]      idle_cnt, idle_cnt_nxt;
    logic [CNT_W:0]        idle_inc;
    logic                  wake, quiet, thresh_on, timeout;

    assign wake      = req | force_on;
    assign quiet     = !(busy | req | force_on);
    assign thresh_on = idle_thresh != '0;
    // One extra bit so the saturated count plus one still compares correctly
    assign idle_inc  = {1'b0, idle_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout   = thresh_on && idle_inc >= {1'b0, idle_thresh};

    // Next-state and counter updates; activity always beats a coincident timeout
    always_comb begin
        state_nxt    = state;
        wake_cnt_nxt = wake_cnt;
        idle_cnt_nxt = idle_cnt;
        case (state)
            OFF: begin
                if (wake) begin
                    state_nxt    = WAKE;
                    wake_cnt_nxt = '0;
                end
            end
            WAKE: begin
                wake_cnt_nxt = wake_cnt + 1'b1;
                if (wake_cnt == WAKE_LAST) state_nxt = ON;
            end
            ON: begin
                if (quiet) begin
                    state_nxt    = IDLE;
                    idle_cnt_nxt = '0;
                end
            end
            IDLE: begin
                if (!quiet) begin
                    state_nxt    = ON;
                    idle_cnt_nxt = '0;
                end else if (timeout) begin
                    state_nxt = OFF;
                end else if (thresh_on) begin
                    idle_cnt_nxt = &idle_cnt ? idle_cnt : idle_inc[CNT_W-1:0];
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    // State and counters, with ack/ch_en registered from the next state so they move with it
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state    <= OFF;
            wake_cnt <= '0;
            idle_cnt <= '0;
            ack      <= 1'b0;
            ch_en    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wake_cnt <= wake_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
            ack      <= state_nxt == ON || state_nxt == IDLE;
            ch_en    <= state_nxt != OFF;
        end
    end

endmodule

// File: rtl/cg_icg_cell.sv
// cg_icg_cell: scan-aware latch-based integrated clock gate
module cg_icg_cell (
    input  logic clk_in,
    input  logic enable,
    input  logic scan_enable,
    output logic gclk
);

    logic en_lat;

    // Enable is captured only while the clock is low, so gclk cannot glitch during the high phase
    always_latch begin
        if (!clk_in) en_lat <= enable | scan_enable;
    end

    assign gclk = clk_in & en_lat;

endmodule

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: independent per-channel wake/idle control driving scan-aware clock gates
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              scan_enable,
    input  logic [CNT_W-1:0]  idle_thresh,
    input  logic [NUM_CH-1:0] force_on,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] gclk_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cg_channel_fsm #(
            .CNT_W    (CNT_W),
            .WAKE_CYC (WAKE_CYC)
        ) u_fsm (
            .clk_in      (clk_in),
            .rst_n       (rst_n),
            .idle_thresh (idle_thresh),
            .force_on    (force_on[i]),
            .req         (req[i]),
            .busy        (busy[i]),
            .ack         (ack[i]),
            .ch_en       (ch_en[i])
        );

        cg_icg_cell u_icg (
            .clk_in      (clk_in),
            .enable      (ch_en[i]),
            .scan_enable (scan_enable),
            .gclk        (gclk_out[i])
        );
    end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl: vector table plus hand sequences checked through an expected-output queue
module tb_clock_gate_ctrl;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int WAKE_CYC = 2;

    logic              clk_in = 1'b0;
    logic              rst_n = 1'b0;
    logic              scan_enable = 1'b0;
    logic [CNT_W-1:0]  idle_thresh = '0;
    logic [NUM_CH-1:0] force_on = '0;
    logic [NUM_CH-1:0] req = '0;
    logic [NUM_CH-1:0] busy = '0;
    logic [NUM_CH-1:0] ack, ch_en, gclk_out;

    clock_gate_ctrl #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .WAKE_CYC (WAKE_CYC)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .scan_enable (scan_enable),
        .idle_thresh (idle_thresh),
        .force_on    (force_on),
        .req         (req),
        .busy        (busy),
        .ack         (ack),
        .ch_en       (ch_en),
        .gclk_out    (gclk_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       r;
        logic [7:0] th;
        logic [3:0] f, rq, b, ea, ee;
    } vec_t;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] ea, ee;
    } exp_t;

    vec_t vec [25];
    exp_t sb [$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0][31:0] pcs, mins;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Per-channel gated clock pulse counter and narrowest high phase seen
    for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
        int  pc = 0;
        int  mn = 1000;
        time tr = 0;
        always @(posedge gclk_out[g]) begin
            pc++;
            tr = $time;
        end
        always @(negedge gclk_out[g]) begin
            if (pc > 0 && $time - tr < time'(mn)) mn = int'($time - tr);
        end
        assign pcs[g]  = pc;
        assign mins[g] = mn;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the coming edge, check them at the next negedge
    task automatic step(input string tag, input logic r, input logic [7:0] th,
                        input logic [3:0] f, input logic [3:0] rq, input logic [3:0] b,
                        input logic [3:0] ea, input logic [3:0] ee);
        exp_t e;
        rst_n = r;
        idle_thresh = th;
        force_on = f;
        req = rq;
        busy = b;
        sb.push_back('{cyc + 1, tag, ea, ee});
        @(negedge clk_in);
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk({e.tag, " ack"}, 32'(ack), 32'(e.ea));
            chk({e.tag, " ch_en"}, 32'(ch_en), 32'(e.ee));
        end
    endtask

    initial begin
        logic [31:0] snap [4];
        // reset, then ch0 one-cycle request and timeout, then ch2 timeout collision
        vec[0]  = '{1'b0, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[1]  = '{1'b0, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[2]  = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[3]  = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[4]  = '{1'b1, 8'd5, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1};
        vec[5]  = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        vec[6]  = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        vec[7]  = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        vec[8]  = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        vec[9]  = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        vec[10] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        vec[11] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        vec[12] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[13] = '{1'b1, 8'd5, 4'h0, 4'h4, 4'h4, 4'h0, 4'h4};
        vec[14] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4};
        vec[15] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4};
        vec[16] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        vec[17] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        vec[18] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        vec[19] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        vec[20] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        vec[21] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4};
        vec[22] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        vec[23] = '{1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        vec[24] = '{1'b1, 8'd0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        for (int k = 0; k < 25; k++)
            step($sformatf("vec%0d", k), vec[k].r, vec[k].th, vec[k].f, vec[k].rq, vec[k].b, vec[k].ea, vec[k].ee);

        // threshold 0 never times out; lowering it gates on the next quiet cycle
        repeat (1000) step("thresh0_hold", 1'b1, 8'd0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4);
        step("thresh_lower", 1'b1, 8'd1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // ch1 busy falls at edge M: gate-off at M+6 with exactly 6 more gated pulses
        step("ch1_wake", 1'b1, 8'd5, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2);
        step("ch1_wake", 1'b1, 8'd5, 4'h0, 4'h0, 4'h2, 4'h0, 4'h2);
        step("ch1_on", 1'b1, 8'd5, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2);
        step("ch1_last_busy", 1'b1, 8'd5, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2);
        snap[1] = pcs[1];
        repeat (5) step("ch1_idle", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2);
        step("ch1_gate", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("ch1_off", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("ch1_tail_pulses", pcs[1] - snap[1], 32'd6);

        // force_on holds ch3 on; release gates off after idle_thresh+1 cycles
        step("ch3_force", 1'b1, 8'd3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8);
        step("ch3_force", 1'b1, 8'd3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8);
        repeat (50) step("ch3_hold", 1'b1, 8'd3, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8);
        repeat (3) step("ch3_idle", 1'b1, 8'd3, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8);
        step("ch3_gate", 1'b1, 8'd3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // reset with ch0 mid-WAKE and ch1 in IDLE
        step("rst_ch1_wake", 1'b1, 8'd5, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2);
        step("rst_ch1_wake", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
        step("rst_ch1_on", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2);
        step("rst_ch1_idle", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2);
        step("rst_ch0_wake", 1'b1, 8'd5, 4'h0, 4'h1, 4'h0, 4'h2, 4'h3);
        step("rst_abort", 1'b0, 8'd5, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);

        // flat gated clocks after reset release, then scan_enable forces them all on
        for (int k = 0; k < 4; k++) snap[k] = pcs[k];
        repeat (20) step("flat", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("flat_pulses%0d", k), pcs[k] - snap[k], 32'd0);
        scan_enable = 1'b1;
        for (int k = 0; k < 4; k++) snap[k] = pcs[k];
        repeat (10) step("scan", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        scan_enable = 1'b0;
        step("scan_off", 1'b1, 8'd5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("scan_pulses%0d", k), pcs[k] - snap[k], 32'd10);

        for (int k = 0; k < 4; k++) chk($sformatf("min_high%0d", k), mins[k], 32'd5);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_gate_ctrl.md
# clock_gate_ctrl

Multi-channel clock-gating controller that owns the enables of `NUM_CH` integrated clock-gating cells, one per downstream DSP sub-domain. Each channel runs its own wake/idle state machine:
- Wakes on request or software force.
- Signals clock-stable via an ack after a fixed wake latency.
- Gates itself off after a programmable number of consecutive idle cycles.

It sits between the subsystem control logic and the existing scan-aware ICG cells, replacing hand-wired per-domain enable logic.

## Interface
Parameters:
- `NUM_CH`, 4: number of gated clock channels.
- `CNT_W`, 8: width of the idle counter and the `idle_thresh` input.
- `WAKE_CYC`, 2: cycles spent in WAKE before ack; legal range 1..15.

Ports:
- `clk_in` input 1: free-running source clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `scan_enable` input 1: DFT bypass; forces all gated clocks on. Does not alter FSM state.
- `idle_thresh` input `CNT_W`: idle cycles before gating; 0 disables auto-gating. Shared by all channels.
- `force_on` input `NUM_CH`: software override per channel; keeps the channel awake.
- `req` input `NUM_CH`: per-channel wake request. Level-sensitive.
- `busy` input `NUM_CH`: per-channel activity; any high cycle resets the idle count.
- `ack` output `NUM_CH`: registered; gated clock is stable and usable.
- `ch_en` output `NUM_CH`: registered enable driven into each ICG `enable`.
- `gclk_out` output `NUM_CH`: gated clocks.

## Operation
- Per-channel FSM states:
  - OFF: `ch_en=0`, `ack=0`.
  - WAKE: `ch_en=1`, `ack=0`.
  - ON: `ch_en=1`, `ack=1`.
  - IDLE: `ch_en=1`, `ack=1`.
- Define `wake = req|force_on` and `quiet = !busy & !req & !force_on`, both per channel.
- OFF → WAKE when `wake`; clear `wake_cnt`.
- WAKE: `wake_cnt` increments each cycle. At `wake_cnt==WAKE_CYC-1` → ON. There is no abort: if `req` drops during WAKE, the channel still completes to ON.
- ON → IDLE when `quiet`; clear `idle_cnt`.
- IDLE → ON when `!quiet`; clear `idle_cnt`.
- IDLE with `quiet` and `idle_thresh!=0`: `idle_cnt` increments, saturating at all-ones.
- IDLE → OFF when `idle_cnt+1 >= idle_thresh` (compared against the live value). Lowering the threshold mid-count therefore gates on the next quiet cycle.
- With `idle_thresh==0`, the channel never leaves IDLE through timeout.
- Simultaneous `!quiet` and timeout in the same cycle: `!quiet` wins, and the channel stays awake.
- `gclk_out[i]` comes from the ICG with `CK=clk_in`, `E=ch_en[i]`, `SE=scan_enable`.
- Channels are fully independent; no shared arbitration.

## Timing
- Reset (`rst_n=0` at an edge):
  - All FSMs go to OFF and all counters clear.
  - `ack=0` and `ch_en=0` from the next edge.
  - `gclk_out` is low unless `scan_enable=1`.
- Reset mid-WAKE, mid-ON or mid-IDLE aborts to OFF with the same values.
- Wake latency, with `req` sampled high at edge N:
  - `ch_en` goes high after edge N.
  - First `gclk_out` pulse occurs in cycle N+1, because the ICG latch is transparent during clock-low.
  - `ack` goes high after edge N+`WAKE_CYC`.
- Gate-off latency:
  - The last busy/req/force cycle is sampled at edge M.
  - With T=`idle_thresh`, the channel enters IDLE at edge M+1.
  - It enters OFF and drops `ch_en` and `ack` together at edge M+T+1.
  - The last `gclk_out` pulse occurs in cycle M+T+1.
- `gclk_out` is glitch-free because `ch_en` only changes after a rising edge and the ICG latch holds while the clock is high.
- `scan_enable` acts combinationally through the ICG and is independent of `rst_n`.

## Structure
- Package `clock_gate_pkg` holds:
  - State encodings as localparams: OFF=2'b00, WAKE=2'b01, ON=2'b10, IDLE=2'b11.
  - Width helper for `wake_cnt` (4 bits).
- Sub-module `cg_channel_fsm` contains one channel's FSM plus its `wake_cnt` and `idle_cnt`. It has `clk_in`, `rst_n`, `idle_thresh`, `force_on`, `req`, `busy`, `ack` and `ch_en` ports.
- Top level contains:
  - A generate loop of `NUM_CH` `cg_channel_fsm` instances.
  - `NUM_CH` instances of the existing scan-enabled clock gating cell.

## Test plan
- Reset release with `req=0` everywhere → `ack=0`, `ch_en=0`, `gclk_out` flat for 20 cycles. With `scan_enable=1`, all `gclk_out` toggle.
- `req[0]` pulsed for 1 cycle with `WAKE_CYC=2` → `ch_en[0]` high the next cycle, `ack[0]` high 2 cycles after the sample, and the channel stays in ON/IDLE until timeout.
- `idle_thresh=5`, `busy[1]` falls at edge M → `ch_en[1]`/`ack[1]` fall at M+6; exactly 6 further `gclk_out[1]` pulses after M.
- Timeout collision: `busy[2]` reasserted on the cycle `idle_cnt` hits the threshold → channel stays awake and `ack[2]` stays high; `idle_thresh=0` → never gates over 1000 quiet cycles.
- `force_on[3]=1` with `req`/`busy` low → channel wakes and holds ON indefinitely. Dropping `force_on` gates off after `idle_thresh+1` cycles.
- `rst_n` asserted mid-WAKE on channel 0 while channel 1 is in IDLE → both go to OFF next edge with `ack=0` and `ch_en=0`, and no runt pulse on `gclk_out`.
